// File: rtl/pll_adc_lock_sequencer_pkg.sv
// Shared types and constants for the ADC clocking PLL lock sequencer and
// the other ADC-domain controllers.
package pll_adc_pkg;

  localparam int LOSS_W  = 8;
  localparam int RETRY_W = 4;

  typedef logic [LOSS_W-1:0]  loss_t;
  typedef logic [RETRY_W-1:0] retry_t;

  typedef enum logic [2:0] {
    ST_RESET     = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_QUALIFY   = 3'd2,
    ST_RUN       = 3'd3,
    ST_FAULT     = 3'd4
  } state_e;

  function automatic int maxOf3(int a, int b, int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  function automatic loss_t satInc(loss_t v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/pll_adc_lock_sequencer_if.sv
// Control/status bundle between the lock sequencer and the PLL/ADC glue.
// Directions are named from the sequencer's side.
interface pll_adc_lock_sequencer_if;
  import pll_adc_pkg::*;

  logic       pll_locked_i;
  logic       restart_i;
  logic       pll_rst_o;
  logic       adc_rst_o;
  logic       ready_o;
  logic       fault_o;
  loss_t      loss_count_o;
  logic [2:0] state_o;

  modport slave (
    input  pll_locked_i, restart_i,
    output pll_rst_o, adc_rst_o, ready_o, fault_o, loss_count_o, state_o
  );

  modport master (
    output pll_locked_i, restart_i,
    input  pll_rst_o, adc_rst_o, ready_o, fault_o, loss_count_o, state_o
  );

endinterface

// File: rtl/pll_adc_lock_sequencer_sync_2ff.sv
// Generic two-flop synchronizer with synchronous active-high reset.
module sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/pll_adc_lock_sequencer.sv
// Walks the ADC PLL through reset, lock acquisition and lock qualification,
// holding the ADC datapath in reset until the lock has been stable long enough.
module pll_adc_lock_sequencer
  import pll_adc_pkg::*;
#(
  parameter int RST_PULSE_CYCLES    = 100,
  parameter int LOCK_STABLE_CYCLES  = 1000,
  parameter int LOCK_TIMEOUT_CYCLES = 100000,
  parameter int MAX_RETRIES         = 3
) (
  input  logic                    refclk,
  input  logic                    rst,
  pll_adc_lock_sequencer_if.slave bus
);

  localparam int CNT_MAX = maxOf3(RST_PULSE_CYCLES, LOCK_STABLE_CYCLES, LOCK_TIMEOUT_CYCLES);
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  typedef logic [CNT_W-1:0] cnt_t;

  localparam cnt_t   RST_LAST     = cnt_t'(RST_PULSE_CYCLES - 1);
  localparam cnt_t   STABLE_LAST  = cnt_t'(LOCK_STABLE_CYCLES - 1);
  localparam cnt_t   TIMEOUT_LAST = cnt_t'(LOCK_TIMEOUT_CYCLES - 1);
  localparam retry_t RETRY_LIMIT  = retry_t'(MAX_RETRIES);

  logic   lk;
  state_e state_q, state_d;
  cnt_t   cycleCount_q, cycleCount_d;
  retry_t retryCount_q, retryCount_d;
  loss_t  lossCount_q, lossCount_d;
  logic   pllRst_q, adcRst_q, ready_q, fault_q;

  sync_2ff #(
    .WIDTH (1)
  ) uLockSync (
    .clk (refclk),
    .rst (rst),
    .d_i (bus.pll_locked_i),
    .q_o (lk)
  );

  // One shared counter times the reset pulse, the lock timeout and the
  // qualification window; it is cleared on every state change.
  always_comb begin
    state_d      = state_q;
    cycleCount_d = cycleCount_q;
    retryCount_d = retryCount_q;
    lossCount_d  = lossCount_q;

    if (state_q == ST_RUN && !lk) begin
      lossCount_d = satInc(lossCount_q);
    end

    if (bus.restart_i) begin
      state_d      = ST_RESET;
      cycleCount_d = '0;
      retryCount_d = '0;
    end else begin
      case (state_q)
        ST_RESET: begin
          if (cycleCount_q == RST_LAST) begin
            state_d      = ST_WAIT_LOCK;
            cycleCount_d = '0;
          end else begin
            cycleCount_d = cycleCount_q + 1'b1;
          end
        end
        ST_WAIT_LOCK: begin
          if (lk) begin
            state_d      = ST_QUALIFY;
            cycleCount_d = '0;
          end else if (cycleCount_q == TIMEOUT_LAST) begin
            retryCount_d = retryCount_q + 1'b1;
            cycleCount_d = '0;
            state_d      = (retryCount_d == RETRY_LIMIT) ? ST_FAULT : ST_RESET;
          end else begin
            cycleCount_d = cycleCount_q + 1'b1;
          end
        end
        ST_QUALIFY: begin
          if (!lk) begin
            state_d      = ST_WAIT_LOCK;
            cycleCount_d = '0;
          end else if (cycleCount_q == STABLE_LAST) begin
            state_d      = ST_RUN;
            cycleCount_d = '0;
            retryCount_d = '0;
          end else begin
            cycleCount_d = cycleCount_q + 1'b1;
          end
        end
        ST_RUN: begin
          if (!lk) begin
            state_d      = ST_RESET;
            cycleCount_d = '0;
          end
        end
        ST_FAULT: begin
          state_d = ST_FAULT;
        end
        default: begin
          state_d      = ST_RESET;
          cycleCount_d = '0;
        end
      endcase
    end
  end

  // Outputs are decoded from the next state so they line up with state_q.
  always_ff @(posedge refclk) begin
    if (rst) begin
      state_q      <= ST_RESET;
      cycleCount_q <= '0;
      retryCount_q <= '0;
      lossCount_q  <= '0;
      pllRst_q     <= 1'b1;
      adcRst_q     <= 1'b1;
      ready_q      <= 1'b0;
      fault_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      cycleCount_q <= cycleCount_d;
      retryCount_q <= retryCount_d;
      lossCount_q  <= lossCount_d;
      pllRst_q     <= (state_d == ST_RESET) || (state_d == ST_FAULT);
      adcRst_q     <= (state_d != ST_RUN);
      ready_q      <= (state_d == ST_RUN);
      fault_q      <= (state_d == ST_FAULT);
    end
  end

  assign bus.pll_rst_o    = pllRst_q;
  assign bus.adc_rst_o    = adcRst_q;
  assign bus.ready_o      = ready_q;
  assign bus.fault_o      = fault_q;
  assign bus.loss_count_o = lossCount_q;
  assign bus.state_o      = state_q;

endmodule

// File: tb/tb_pll_adc_lock_sequencer.sv
// Bench for pll_adc_lock_sequencer: directed lock scenarios followed by
// random lock/restart/reset traffic, all checked against a phase-age model.
module tb_pll_adc_lock_sequencer;

  localparam int RST_P   = 4;
  localparam int STABLE  = 8;
  localparam int TIMEOUT = 32;
  localparam int MAXR    = 2;

  logic refclk = 1'b0;
  logic rst    = 1'b1;

  pll_adc_lock_sequencer_if bus();

  pll_adc_lock_sequencer #(
    .RST_PULSE_CYCLES    (RST_P),
    .LOCK_STABLE_CYCLES  (STABLE),
    .LOCK_TIMEOUT_CYCLES (TIMEOUT),
    .MAX_RETRIES         (MAXR)
  ) dut (
    .refclk (refclk),
    .rst    (rst),
    .bus    (bus)
  );

  always #5 refclk = ~refclk;

  int vectors     = 0;
  int miscompares = 0;

  // Model: phase number, the edge it was entered on, and the lock samples
  // still travelling through the synchronizer.
  int mCycle   = 0;
  int mEntered = 0;
  int mPhase   = 0;
  int mRetries = 0;
  int mLoss    = 0;
  bit lkQ[$];

  int hiRun      = 0;
  int lastPulse  = 0;
  int pulseCount = 0;

  initial begin
    bus.pll_locked_i = 1'b0;
    bus.restart_i    = 1'b0;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    if (observed !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: observed %0d, expected %0d at cycle %0d", tag, observed, expected, mCycle);
    end
  endtask

  task automatic modelStep(input bit r, input bit rs, input bit lock);
    bit lk;
    int age;
    int nextPhase;
    mCycle++;
    if (r) begin
      mPhase   = 0;
      mEntered = mCycle;
      mRetries = 0;
      mLoss    = 0;
      lkQ      = {};
      lkQ.push_back(1'b0);
      lkQ.push_back(1'b0);
      return;
    end
    lk = lkQ.pop_front();
    lkQ.push_back(lock);
    age       = mCycle - mEntered;
    nextPhase = mPhase;
    if (mPhase == 3 && !lk) mLoss = (mLoss < 255) ? mLoss + 1 : 255;
    if (rs) begin
      nextPhase = 0;
      mRetries  = 0;
    end else begin
      case (mPhase)
        0: if (age == RST_P) nextPhase = 1;
        1: begin
          if (lk) nextPhase = 2;
          else if (age == TIMEOUT) begin
            mRetries++;
            nextPhase = (mRetries == MAXR) ? 4 : 0;
          end
        end
        2: begin
          if (!lk) nextPhase = 1;
          else if (age == STABLE) begin
            nextPhase = 3;
            mRetries  = 0;
          end
        end
        3: if (!lk) nextPhase = 0;
        default: nextPhase = mPhase;
      endcase
    end
    if (nextPhase != mPhase || rs) mEntered = mCycle;
    mPhase = nextPhase;
  endtask

  function automatic logic [3:0] expFlags();
    return {(mPhase == 0) || (mPhase == 4), mPhase != 3, mPhase == 3, mPhase == 4};
  endfunction

  task automatic applyStimulus(input bit r, input bit rs, input bit lock);
    @(negedge refclk);
    rst              = r;
    bus.restart_i    = rs;
    bus.pll_locked_i = lock;
    @(posedge refclk);
    #1;
    modelStep(r, rs, lock);
    checkOutput("state", 32'(bus.state_o), 32'(mPhase));
    checkOutput("flags", 32'({bus.pll_rst_o, bus.adc_rst_o, bus.ready_o, bus.fault_o}), 32'(expFlags()));
    checkOutput("lossCount", 32'(bus.loss_count_o), 32'(mLoss));
    if (bus.pll_rst_o === 1'b1) begin
      hiRun = (r || rs) ? 1 : hiRun + 1;
    end else if (hiRun > 0) begin
      lastPulse = hiRun;
      pulseCount++;
      hiRun = 0;
    end
  endtask

  task automatic waitReady(output int n, output bit sawWait);
    n       = 0;
    sawWait = 1'b0;
    do begin
      applyStimulus(1'b0, 1'b0, 1'b1);
      n++;
      if (bus.state_o == 3'd1) sawWait = 1'b1;
    end while (bus.ready_o !== 1'b1 && n < 60);
    checkOutput("readyReached", 32'(bus.ready_o), 32'd1);
  endtask

  initial begin
    int  n;
    bit  saw;
    int  p0;
    int  waitCnt;
    bit  lvl;
    int  len;

    applyStimulus(1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("rstState", 32'(bus.state_o), 32'd0);
    checkOutput("rstPllRst", 32'(bus.pll_rst_o), 32'd1);
    checkOutput("rstAdcRst", 32'(bus.adc_rst_o), 32'd1);
    checkOutput("rstReady", 32'(bus.ready_o), 32'd0);
    checkOutput("rstFault", 32'(bus.fault_o), 32'd0);
    checkOutput("rstLoss", 32'(bus.loss_count_o), 32'd0);

    repeat (10) applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("nomPulseWidth", 32'(lastPulse), 32'd4);
    waitReady(n, saw);
    checkOutput("nomLatency", 32'(n), 32'd11);
    checkOutput("nomAdcRst", 32'(bus.adc_rst_o), 32'd0);

    n = 0;
    do begin
      applyStimulus(1'b0, 1'b0, 1'b0);
      n++;
    end while (bus.ready_o === 1'b1 && n < 20);
    checkOutput("lossLatency", 32'(n), 32'd3);
    checkOutput("lossAdcRst", 32'(bus.adc_rst_o), 32'd1);
    checkOutput("lossCount1", 32'(bus.loss_count_o), 32'd1);
    repeat (10) applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("lossPulseWidth", 32'(lastPulse), 32'd4);

    repeat (5) applyStimulus(1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b0);
    waitReady(n, saw);
    checkOutput("glitchLatency", 32'(n), 32'd11);
    checkOutput("glitchSawWait", 32'(saw), 32'd1);

    repeat (2) applyStimulus(1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput("restartLossState", 32'(bus.state_o), 32'd0);
    checkOutput("restartLossCount", 32'(bus.loss_count_o), 32'd2);
    waitReady(n, saw);

    p0      = pulseCount;
    waitCnt = 0;
    n       = 0;
    do begin
      applyStimulus(1'b0, 1'b0, 1'b0);
      n++;
      if (bus.state_o == 3'd1) waitCnt++;
    end while (bus.state_o != 3'd4 && n < 200);
    checkOutput("faultState", 32'(bus.state_o), 32'd4);
    checkOutput("faultFlag", 32'(bus.fault_o), 32'd1);
    checkOutput("faultPllRst", 32'(bus.pll_rst_o), 32'd1);
    checkOutput("faultPulses", 32'(pulseCount - p0), 32'd2);
    checkOutput("faultWaitCycles", 32'(waitCnt), 32'd64);
    checkOutput("faultPulseWidth", 32'(lastPulse), 32'd4);
    repeat (5) applyStimulus(1'b0, 1'b0, 1'b1);
    checkOutput("faultHold", 32'(bus.state_o), 32'd4);

    applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput("restartFault", 32'(bus.fault_o), 32'd0);
    checkOutput("restartState", 32'(bus.state_o), 32'd0);
    repeat (6) applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("restartPulseWidth", 32'(lastPulse), 32'd4);
    waitReady(n, saw);
    checkOutput("restartLatency", 32'(n), 32'd11);

    for (int i = 0; i < 300; i++) begin
      repeat (3) applyStimulus(1'b0, 1'b0, 1'b0);
      waitReady(n, saw);
    end
    checkOutput("lossSaturate", 32'(bus.loss_count_o), 32'd255);

    repeat (8) applyStimulus(1'b0, 1'b0, 1'b0);
    repeat (5) applyStimulus(1'b0, 1'b0, 1'b1);
    checkOutput("midQualState", 32'(bus.state_o), 32'd2);
    applyStimulus(1'b1, 1'b0, 1'b1);
    checkOutput("midRstState", 32'(bus.state_o), 32'd0);
    checkOutput("midRstPllRst", 32'(bus.pll_rst_o), 32'd1);
    checkOutput("midRstAdcRst", 32'(bus.adc_rst_o), 32'd1);
    checkOutput("midRstLoss", 32'(bus.loss_count_o), 32'd0);

    applyStimulus(1'b0, 1'b0, 1'b0);
    for (int seg = 0; seg < 150; seg++) begin
      lvl = ($urandom_range(0, 3) != 0);
      len = lvl ? $urandom_range(1, 60) : $urandom_range(1, 50);
      for (int k = 0; k < len; k++) begin
        applyStimulus($urandom_range(0, 299) == 0, $urandom_range(0, 63) == 0, lvl);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/pll_adc_lock_sequencer.md
# pll_adc_lock_sequencer

Sequences the ADC clocking PLL (100 MHz reference in, 50/100 MHz out) through reset, lock acquisition and lock qualification. It holds the ADC datapath in reset until the PLL lock has been stable for a programmable time. On loss of lock it re-runs the sequence, and after repeated acquisition timeouts it latches a fault. It sits beside the PLL wrapper, runs on the free-running reference clock, and drives the PLL reset and the ADC-domain reset request.

## Interface
Parameters:
- RST_PULSE_CYCLES, 100: width of PLL reset pulse, in refclk cycles (1 µs).
- LOCK_STABLE_CYCLES, 1000: consecutive synchronized-locked cycles required before release.
- LOCK_TIMEOUT_CYCLES, 100000: maximum cycles in WAIT_LOCK before a retry (1 ms).
- MAX_RETRIES, 3: consecutive timeouts before FAULT; range 1..15.

Ports:
- refclk, in, 1: free-running reference clock, the only clock.
- rst, in, 1: synchronous, active-high reset.
- pll_locked, in, 1: PLL lock flag; asynchronous to refclk.
- restart, in, 1: single-cycle request to restart the sequence from any state; clears the retry count and the fault.
- pll_rst, out, 1: reset to the PLL.
- adc_rst, out, 1: reset request to the ADC datapath.
- ready, out, 1: PLL qualified and ADC released.
- fault, out, 1: retry budget exhausted.
- loss_count, out, 8: saturating count of lock losses seen in RUN.
- state, out, 3: current state encoding, for debug.

## Operation
- pll_locked passes through a 2-flop synchronizer; all decisions use the synchronized value `lk`.
- States: RESET=0, WAIT_LOCK=1, QUALIFY=2, RUN=3, FAULT=4.
- RESET: pll_rst=1. Count RST_PULSE_CYCLES cycles, then go to WAIT_LOCK with the counter cleared.
- WAIT_LOCK: pll_rst=0.
  - `lk`=1: go to QUALIFY, counter cleared.
  - Counter reaches LOCK_TIMEOUT_CYCLES-1 with `lk`=0: increment retries. If retries now equals MAX_RETRIES, go to FAULT; otherwise go to RESET.
- QUALIFY:
  - `lk`=0: return to WAIT_LOCK with the counter cleared. The timeout restarts and retries are not incremented.
  - LOCK_STABLE_CYCLES consecutive `lk`=1 cycles: go to RUN and clear retries.
- RUN: adc_rst=0 and ready=1. On `lk`=0, increment loss_count (saturating at 255) and go to RESET.
- FAULT: pll_rst=1, adc_rst=1, fault=1. Only restart or rst leaves this state.
- restart in any state goes to RESET with counter=0, retries=0 and fault cleared. loss_count is not cleared.
- Priority: rst > restart > state transitions. A restart in the same cycle as a RUN loss still increments loss_count.
- adc_rst=1 in every state except RUN. ready=1 only in RUN.
- Use one shared cycle counter, sized to the largest of the three cycle parameters. Retries are held in a 4-bit counter.

## Timing
- Reset values: pll_rst=1, adc_rst=1, ready=0, fault=0, loss_count=0, state=RESET. The synchronizer flops reset to 0.
- All outputs are registered and decoded from the state register. Outputs change in the cycle after the transition condition is sampled.
- Lock loss to adc_rst=1: a `pll_locked` fall reaches `lk` 2 cycles later; the state and outputs update 1 cycle after that, so 3 cycles total.
- pll_rst pulse width is exactly RST_PULSE_CYCLES cycles per entry into RESET.
- Lock-to-ready latency, measured from `pll_locked` rising to ready=1: 2 sync cycles + 1 WAIT_LOCK exit + LOCK_STABLE_CYCLES.
- A mid-operation rst is honoured on the next edge, regardless of state.

## Structure
- Shared package pll_adc_pkg holds:
  - the state enum (3 bits);
  - the loss_count width constant (8);
  - the retry width constant (4).
- One sub-module: sync_2ff, a generic 2-flop synchronizer with synchronous reset. It is reused later by the other ADC-domain controllers.

## Test plan
All scenarios use RST_PULSE_CYCLES=4, LOCK_STABLE_CYCLES=8, LOCK_TIMEOUT_CYCLES=32, MAX_RETRIES=2.
- Nominal: release rst and raise pll_locked 10 cycles later -> pll_rst high for exactly 4 cycles; ready=1 and adc_rst=0 exactly 11 cycles after pll_locked rises.
- Glitch during QUALIFY: pll_locked high 5 cycles, low 1 cycle, then high -> state returns to WAIT_LOCK; ready follows the second rise by 11 cycles; retry count stays 0.
- Timeout and fault: pll_locked held 0 -> two 4-cycle pll_rst pulses separated by 32 WAIT_LOCK cycles, then state=4, fault=1, pll_rst=1.
- Restart from FAULT: pulse restart -> fault=0 next cycle, a new 4-cycle pll_rst pulse; locking then reaches ready normally.
- Loss in RUN: drop pll_locked while ready=1 -> adc_rst=1 and ready=0 3 cycles later; loss_count=1; a fresh pll_rst pulse. Force 300 losses -> loss_count=255.
- Reset mid-QUALIFY: assert rst -> next edge shows pll_rst=1, adc_rst=1, state=0; loss_count=0.
